// File: rtl/timekeeper_core_pkg.sv
// Shared types, limits and the 12 h display conversion for the time-of-day engine.
// Contents: bcd_t digit type, counter limits, hr_disp_t hour-display payload, to_12h().
package timekeeper_core_pkg;

  localparam int unsigned BCD_W        = 4;
  localparam int unsigned SEC_W        = 6;
  localparam int unsigned SEC_MAX      = 59;
  localparam int unsigned MIN_TENS_MAX = 5;
  localparam int unsigned HR_MAX_T     = 2;
  localparam int unsigned HR_MAX_O     = 3;

  typedef logic [BCD_W-1:0] bcd_t;

  // Hour digits as shown on the display, with the PM flag
  typedef struct packed {
    bcd_t tens;
    bcd_t ones;
    logic pm;
  } hr_disp_t;

  // Map a 24 h BCD hour (00..23) to its 12 h form: 0 -> 12 AM, 12 -> 12 PM
  function automatic hr_disp_t to_12h(input bcd_t h_t, input bcd_t h_o);
    logic [4:0] h;
    logic [4:0] d;
    hr_disp_t   r;
    h    = 5'(h_t) * 5'd10 + 5'(h_o);
    r.pm = (h >= 5'd12);
    if (h == 5'd0)       d = 5'd12;
    else if (h > 5'd12)  d = h - 5'd12;
    else                 d = h;
    r.tens = (d >= 5'd10) ? 4'd1 : 4'd0;
    r.ones = 4'(d - ((d >= 5'd10) ? 5'd10 : 5'd0));
    return r;
  endfunction

endpackage

// File: rtl/timekeeper_core_bcd_mod_counter.sv
// Two-digit BCD counter that wraps to 00 after TENS_MAX:WRAP_O.
// Ports: i_clk clock, i_clr sync clear (priority), i_inc advance by one,
//        o_tens/o_ones current digits, o_wrap_c combinational: this i_inc wraps to 00.
module timekeeper_core_bcd_mod_counter
  import timekeeper_core_pkg::*;
#(
  parameter int unsigned TENS_MAX = 5,
  parameter int unsigned ONES_MAX = 9,
  parameter int unsigned WRAP_O   = 9
) (
  input  logic i_clk,
  input  logic i_clr,
  input  logic i_inc,
  output bcd_t o_tens,
  output bcd_t o_ones,
  output logic o_wrap_c
);

  bcd_t r_tens;
  bcd_t r_ones;
  logic w_at_wrap;

  assign w_at_wrap = (r_tens == BCD_W'(TENS_MAX)) && (r_ones == BCD_W'(WRAP_O));
  assign o_wrap_c  = i_inc && w_at_wrap;
  assign o_tens    = r_tens;
  assign o_ones    = r_ones;

  // Digit update: wrap point first, then ones overflow into tens
  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      r_tens <= '0;
      r_ones <= '0;
    end else if (i_inc) begin
      if (w_at_wrap) begin
        r_tens <= '0;
        r_ones <= '0;
      end else if (r_ones == BCD_W'(ONES_MAX)) begin
        r_tens <= r_tens + BCD_W'(1);
        r_ones <= '0;
      end else begin
        r_ones <= r_ones + BCD_W'(1);
      end
    end
  end

endmodule

// File: rtl/timekeeper_core.sv
// Time-of-day engine: prescaler, seconds, BCD minutes/hours, registered 24/12 h display.
// Ports: CLK100MHZ clock, Reset sync active-high; inc_min/inc_hr one-cycle set pulses;
//        mode_12h display format; run enables the prescaler.
//        hrs_tens/hrs_ones/min_tens/min_ones BCD digits, seconds binary 0..59, pm flag,
//        sec_pulse one cycle per seconds tick, hour_wrap one cycle on 23 -> 00.
module timekeeper_core
  import timekeeper_core_pkg::*;
#(
  parameter int unsigned TICK_DIV       = 100000000,
  parameter int unsigned CNT_W          = $clog2(TICK_DIV),
  parameter bit          SET_CLEARS_SEC = 1'b1
) (
  input  logic             CLK100MHZ,
  input  logic             Reset,
  input  logic             inc_min,
  input  logic             inc_hr,
  input  logic             mode_12h,
  input  logic             run,
  output logic [BCD_W-1:0] hrs_tens,
  output logic [BCD_W-1:0] hrs_ones,
  output logic [BCD_W-1:0] min_tens,
  output logic [BCD_W-1:0] min_ones,
  output logic [SEC_W-1:0] seconds,
  output logic             pm,
  output logic             sec_pulse,
  output logic             hour_wrap
);

  logic [CNT_W-1:0] r_presc;
  logic [SEC_W-1:0] r_sec;
  logic             r_sec_pulse;
  logic             r_hour_wrap;
  bcd_t             r_hrs_t, r_hrs_o, r_min_t, r_min_o;
  logic [SEC_W-1:0] r_sec_disp;
  logic             r_pm;

  logic     w_tick, w_set_clr, w_sec_carry;
  logic     w_min_inc, w_min_wrap, w_hr_carry, w_hr_inc, w_hr_wrap;
  bcd_t     w_m_t, w_m_o, w_h_t, w_h_o;
  bcd_t     w_src_h_t, w_src_h_o;
  hr_disp_t w_disp12;

  assign w_tick      = run && (r_presc == CNT_W'(TICK_DIV - 1));
  assign w_set_clr   = SET_CLEARS_SEC && (inc_min || inc_hr);
  // A set pulse zeroes seconds, so a coincident 59 -> 0 tick never carries
  assign w_sec_carry = w_tick && !w_set_clr && (r_sec == SEC_W'(SEC_MAX));
  assign w_min_inc   = w_sec_carry || inc_min;
  // Only a carry-driven minute wrap reaches the hours
  assign w_hr_carry  = w_min_wrap && !inc_min;
  assign w_hr_inc    = w_hr_carry || inc_hr;

  timekeeper_core_bcd_mod_counter #(
    .TENS_MAX(MIN_TENS_MAX), .ONES_MAX(9), .WRAP_O(9)
  ) u_min (
    .i_clk(CLK100MHZ), .i_clr(Reset), .i_inc(w_min_inc),
    .o_tens(w_m_t), .o_ones(w_m_o), .o_wrap_c(w_min_wrap)
  );

  timekeeper_core_bcd_mod_counter #(
    .TENS_MAX(HR_MAX_T), .ONES_MAX(9), .WRAP_O(HR_MAX_O)
  ) u_hr (
    .i_clk(CLK100MHZ), .i_clr(Reset), .i_inc(w_hr_inc),
    .o_tens(w_h_t), .o_ones(w_h_o), .o_wrap_c(w_hr_wrap)
  );

  // Prescaler, seconds and event pulses
  always_ff @(posedge CLK100MHZ) begin
    if (Reset) begin
      r_presc     <= '0;
      r_sec       <= '0;
      r_sec_pulse <= 1'b0;
      r_hour_wrap <= 1'b0;
    end else begin
      if (w_set_clr) begin
        r_presc <= '0;
        r_sec   <= '0;
      end else if (w_tick) begin
        r_presc <= '0;
        r_sec   <= (r_sec == SEC_W'(SEC_MAX)) ? '0 : r_sec + SEC_W'(1);
      end else if (run) begin
        r_presc <= r_presc + CNT_W'(1);
      end
      r_sec_pulse <= w_tick && !w_set_clr;
      r_hour_wrap <= w_hr_wrap;
    end
  end

  // During Reset the display loads the cleared state so the cycle after shows 00:00 / 12:00
  assign w_src_h_t = Reset ? '0 : w_h_t;
  assign w_src_h_o = Reset ? '0 : w_h_o;
  assign w_disp12  = to_12h(w_src_h_t, w_src_h_o);

  // Display registers, one cycle behind the counters
  always_ff @(posedge CLK100MHZ) begin
    r_min_t    <= Reset ? '0 : w_m_t;
    r_min_o    <= Reset ? '0 : w_m_o;
    r_sec_disp <= Reset ? '0 : r_sec;
    if (mode_12h) begin
      r_hrs_t <= w_disp12.tens;
      r_hrs_o <= w_disp12.ones;
      r_pm    <= w_disp12.pm;
    end else begin
      r_hrs_t <= w_src_h_t;
      r_hrs_o <= w_src_h_o;
      r_pm    <= 1'b0;
    end
  end

  assign hrs_tens  = r_hrs_t;
  assign hrs_ones  = r_hrs_o;
  assign min_tens  = r_min_t;
  assign min_ones  = r_min_o;
  assign seconds   = r_sec_disp;
  assign pm        = r_pm;
  assign sec_pulse = r_sec_pulse;
  assign hour_wrap = r_hour_wrap;

endmodule

// File: tb/tb_timekeeper_core.sv
// Bench for timekeeper_core: directed scenarios plus randomized traffic against a
// wall-clock reference model held as plain integers (seconds, minutes, hours).
module tb_timekeeper_core;

  localparam int unsigned TICK_DIV = 4;

  logic       clk;
  logic       rst, inc_min, inc_hr, mode_12h, run;
  logic [3:0] hrs_tens, hrs_ones, min_tens, min_ones;
  logic [5:0] seconds;
  logic       pm, sec_pulse, hour_wrap;

  timekeeper_core #(
    .TICK_DIV(TICK_DIV), .SET_CLEARS_SEC(1'b1)
  ) dut (
    .CLK100MHZ(clk), .Reset(rst), .inc_min(inc_min), .inc_hr(inc_hr),
    .mode_12h(mode_12h), .run(run),
    .hrs_tens(hrs_tens), .hrs_ones(hrs_ones), .min_tens(min_tens), .min_ones(min_ones),
    .seconds(seconds), .pm(pm), .sec_pulse(sec_pulse), .hour_wrap(hour_wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int pulse_cnt = 0;

  // Reference time state
  int m_presc = 0, m_sec = 0, m_min = 0, m_hr = 0;
  // Expected outputs after the current edge
  int e_hr, e_min, e_sec, e_pm, e_sp, e_hw;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] bcd2(input int v);
    return 32'((v / 10) * 16 + (v % 10));
  endfunction

  // One clock: drive inputs, advance the reference, compare every output
  task automatic step(input bit r, input bit im, input bit ih, input bit m12, input bit rn);
    int dh;
    bit tick, setc, sc, hc;
    @(negedge clk);
    rst = r; inc_min = im; inc_hr = ih; mode_12h = m12; run = rn;
    @(posedge clk);
    if (r) begin
      e_hr = m12 ? 12 : 0; e_min = 0; e_sec = 0; e_pm = 0; e_sp = 0; e_hw = 0;
      m_presc = 0; m_sec = 0; m_min = 0; m_hr = 0;
    end else begin
      if (m12) begin
        dh   = (m_hr % 12 == 0) ? 12 : m_hr % 12;
        e_pm = (m_hr >= 12) ? 1 : 0;
      end else begin
        dh   = m_hr;
        e_pm = 0;
      end
      e_hr  = dh;
      e_min = m_min;
      e_sec = m_sec;
      tick  = rn && (m_presc == int'(TICK_DIV) - 1);
      setc  = im || ih;
      sc    = tick && !setc && (m_sec == 59);
      hc    = sc && !im && (m_min == 59);
      e_sp  = (tick && !setc) ? 1 : 0;
      e_hw  = ((hc || ih) && m_hr == 23) ? 1 : 0;
      if (setc) begin
        m_sec = 0; m_presc = 0;
      end else if (tick) begin
        m_sec = (m_sec + 1) % 60; m_presc = 0;
      end else if (rn) begin
        m_presc++;
      end
      if (sc || im) m_min = (m_min + 1) % 60;
      if (hc || ih) m_hr = (m_hr + 1) % 24;
    end
    #1;
    check("hrs",       32'({hrs_tens, hrs_ones}), bcd2(e_hr));
    check("min",       32'({min_tens, min_ones}), bcd2(e_min));
    check("seconds",   32'(seconds),   32'(e_sec));
    check("pm",        32'(pm),        32'(e_pm));
    check("sec_pulse", 32'(sec_pulse), 32'(e_sp));
    check("hour_wrap", 32'(hour_wrap), 32'(e_hw));
    if (sec_pulse === 1'b1) pulse_cnt++;
  endtask

  task automatic run_steps(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  // Reset, then set h:m with pulses and run s whole seconds (prescaler ends at 0)
  task automatic preload(input int h, input int m, input int s);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < h; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < m; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    run_steps(s * int'(TICK_DIV));
  endtask

  initial begin
    bit m12r;
    rst = 1'b1; inc_min = 1'b0; inc_hr = 1'b0; mode_12h = 1'b0; run = 1'b0;

    // Free run from reset: 60 seconds make one minute
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    check("reset_hrs", 32'({hrs_tens, hrs_ones}), 32'h00);
    check("reset_pm",  32'(pm), 32'h0);
    pulse_cnt = 0;
    run_steps(241);
    check("minute_pulses", 32'(pulse_cnt), 32'd60);
    check("minute_min",    32'({min_tens, min_ones}), 32'h01);
    check("minute_sec",    32'(seconds), 32'd0);

    // 23:59:59 rolls to 00:00:00 with one hour_wrap
    preload(23, 59, 59);
    run_steps(3);
    run_steps(1);
    check("wrap_pulse", 32'(hour_wrap), 32'h1);
    run_steps(1);
    check("wrap_hrs",   32'({hrs_tens, hrs_ones}), 32'h00);
    check("wrap_min",   32'({min_tens, min_ones}), 32'h00);
    check("wrap_sec",   32'(seconds), 32'd0);
    check("wrap_pm",    32'(pm), 32'h0);
    check("wrap_once",  32'(hour_wrap), 32'h0);

    // inc_min at 10:59 wraps minutes only and restarts the second
    preload(10, 59, 0);
    run_steps(2);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    run_steps(1);
    check("setmin_hrs", 32'({hrs_tens, hrs_ones}), 32'h10);
    check("setmin_min", 32'({min_tens, min_ones}), 32'h00);
    check("setmin_sec", 32'(seconds), 32'd0);
    run_steps(2);
    check("setmin_presc_early", 32'(sec_pulse), 32'h0);
    run_steps(1);
    check("setmin_presc_tick",  32'(sec_pulse), 32'h1);

    // inc_min coincident with the 59 -> 0 tick at 10:15 gives 10:16
    preload(10, 15, 59);
    run_steps(3);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    run_steps(1);
    check("absorb_hrs", 32'({hrs_tens, hrs_ones}), 32'h10);
    check("absorb_min", 32'({min_tens, min_ones}), 32'h16);
    check("absorb_sec", 32'(seconds), 32'd0);

    // 12 h display of 00, 12, 13, 23, then back to 24 h
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    check("h12_00_hrs", 32'({hrs_tens, hrs_ones}), 32'h12);
    check("h12_00_pm",  32'(pm), 32'h0);
    for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("h12_12_hrs", 32'({hrs_tens, hrs_ones}), 32'h12);
    check("h12_12_pm",  32'(pm), 32'h1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("h24_12_hrs", 32'({hrs_tens, hrs_ones}), 32'h12);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("h12_13_hrs", 32'({hrs_tens, hrs_ones}), 32'h01);
    check("h12_13_pm",  32'(pm), 32'h1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("h24_13_hrs", 32'({hrs_tens, hrs_ones}), 32'h13);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("h12_23_hrs", 32'({hrs_tens, hrs_ones}), 32'h11);
    check("h12_23_pm",  32'(pm), 32'h1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("h24_23_hrs", 32'({hrs_tens, hrs_ones}), 32'h23);
    check("h24_23_pm",  32'(pm), 32'h0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("hr_set_wrap", 32'(hour_wrap), 32'h1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("h24_00_hrs", 32'({hrs_tens, hrs_ones}), 32'h00);

    // Reset mid-count at 14:37:22 with a tick pending
    preload(14, 37, 22);
    run_steps(3);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    check("midrst_hrs",  32'({hrs_tens, hrs_ones}), 32'h00);
    check("midrst_min",  32'({min_tens, min_ones}), 32'h00);
    check("midrst_sec",  32'(seconds), 32'd0);
    check("midrst_sp0",  32'(sec_pulse), 32'h0);
    check("midrst_hw0",  32'(hour_wrap), 32'h0);
    run_steps(1);
    check("midrst_sp1",  32'(sec_pulse), 32'h0);
    check("midrst_hw1",  32'(hour_wrap), 32'h0);

    // Randomized traffic against the reference model
    m12r = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 49) == 0) m12r = ~m12r;
      step($urandom_range(0, 599) == 0,
           $urandom_range(0, 19) == 0,
           $urandom_range(0, 24) == 0,
           m12r,
           $urandom_range(0, 7) != 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/timekeeper_core.md
Name: timekeeper_core

Overview:
- Parametrised time-of-day engine for the board display path.
- Contains a clock prescaler, a seconds counter, and BCD minute and hour counters.
- Accepts one-cycle set pulses from the debounce stage.
- Drives registered BCD digits in 24 h or 12 h format to the seven-segment driver.
- Generalises the fixed-rate wall clock: configurable tick rate, runtime 12/24 h mode, PM flag, and defined set and collision semantics.

Parameters:
- TICK_DIV, 100000000, CLK100MHZ cycles per second; must be ≥ 2. Benches use small values.
- CNT_W, $clog2(TICK_DIV), prescaler width.
- SET_CLEARS_SEC, 1, when 1 any inc_min or inc_hr pulse zeroes seconds and the prescaler.

Ports:
- CLK100MHZ  in  1  system clock
- Reset  in  1  synchronous, active-high, highest priority
- inc_min  in  1  one-cycle pulse (debounced): advance minutes
- inc_hr  in  1  one-cycle pulse (debounced): advance hours
- mode_12h  in  1  0 = 24 h display, 1 = 12 h display; sampled every cycle
- run  in  1  1 = prescaler counts, 0 = time frozen (set pulses still act)
- hrs_tens  out  4  BCD display digit
- hrs_ones  out  4  BCD display digit
- min_tens  out  4  BCD display digit
- min_ones  out  4  BCD display digit
- seconds  out  6  binary, 0..59
- pm  out  1  1 = PM; forced 0 in 24 h mode
- sec_pulse  out  1  high one cycle per seconds increment
- hour_wrap  out  1  high one cycle when hours roll 23→00, from either the carry or inc_hr

Behaviour:
- Internal state is kept in 24 h BCD: h_t (0..2), h_o, m_t (0..5), m_o, sec, presc.
- Reset: all state is 0 (00:00:00).
  - Outputs one cycle after Reset in 24 h mode: all digits 0, pm=0, pulses 0.
  - Outputs one cycle after Reset in 12 h mode: 12:00, pm=0.
- Prescaler: when run=1, presc counts 0..TICK_DIV-1; on TICK_DIV-1 it wraps to 0 and asserts an internal tick.
- Seconds: tick advances sec; 59→0 generates a minute carry.
  - sec_pulse is registered: high the cycle after sec changes due to tick.
- Minutes: BCD 00..59.
  - A carry or inc_min advances minutes by exactly one.
  - Carry-driven 59→00 generates an hour carry.
  - inc_min-driven 59→00 wraps minutes only; hours are unchanged.
- Hours: BCD 00..23; 23→00 wraps.
  - An hour carry or inc_hr advances hours by one.
  - If both occur in the same cycle, hours still advance by one only.
- Set pulses with SET_CLEARS_SEC=1: sec←0 and presc←0 in the same cycle.
  - A tick or minute carry coincident with inc_min is absorbed: minutes advance once; no extra hour carry.
- inc_min and inc_hr in the same cycle: both apply, minutes +1 and hours +1, with no cross-carry.
- run=0 freezes presc; sec, minutes and hours change only via set pulses.
- Display conversion (registered, 1-cycle latency from state):
  - 24 h mode: digits = state, pm=0.
  - 12 h mode:
    - h=0 → 12, pm=0
    - h=1..11 → h, pm=0
    - h=12 → 12, pm=1
    - h=13..23 → h-12, pm=1
- mode_12h toggling affects only the display; the counters are untouched; the new format appears 1 cycle later.
- Reset mid-count discards all pending carries; no pulse is emitted in the Reset cycle or the cycle after.
- No output is combinational from inputs.

Decomposition:
- Shared package holds:
  - BCD digit typedef (4 bits)
  - constants SEC_MAX=59, MIN_TENS_MAX=5, HR_MAX_T=2, HR_MAX_O=3
  - the 12 h conversion function
- One sub-module is natural: bcd_mod_counter.
  - Parametrised two-digit BCD counter with TENS_MAX/ONES_MAX/wrap point.
  - Ports: inc, clr, wrap pulse.
  - Instantiated for minutes and for hours (hours use a 23 wrap override).

Test Plan:
- TICK_DIV=4, run=1, from Reset: after 240 cycles → min_ones=1, seconds=0; sec_pulse asserted exactly 60 times.
- Preload 23:59:59 via set pulses and ticks, TICK_DIV=4: next tick → 00:00:00; hour_wrap asserted one cycle; pm=0.
- State 10:59, inc_min pulse → 10:00 (hours unchanged), seconds=0, presc=0.
- inc_min coincident with the tick that takes sec 59→0 at 10:15 → 10:16, not 10:17.
- mode_12h=1: hours 00, 12, 13, 23 → displays 12/pm0, 12/pm1, 01/pm1, 11/pm1; toggling back to 0 gives 00, 12, 13, 23.
- Reset asserted mid-count at 14:37:22, run=1 → outputs 00:00, seconds=0 one cycle later; no sec_pulse or hour_wrap in the Reset cycle or the following cycle.
